// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared encodings and counter helpers for the branch resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

   // Branch condition encodings (func3)
   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic [1:0] {
      KIND_BRANCH = 2'd0,
      KIND_JAL    = 2'd1,
      KIND_JALR   = 2'd2,
      KIND_RSVD   = 2'd3
   } kind_e;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_INIT = 2'b01;
   localparam ctr_t CTR_MAX  = 2'b11;
   localparam ctr_t CTR_MIN  = 2'b00;

   function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
      ctr_t nxt;
      nxt = cur;
      if (taken) begin
         if (cur != CTR_MAX) nxt = cur + 2'd1;
      end else begin
         if (cur != CTR_MIN) nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bht_2bit.sv
// ============================================================================
// Module      : bht_2bit
// Description : Array of 2-bit saturating counters, one async read, one update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_2bit
   import branch_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   ctr_t ctr_q [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
      end
   end

   // Reads the registered array, so a same-cycle update is seen next cycle.
   assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves branches/JAL/JALR, flags mispredicts, trains the BHT.
//               Optional BRU_PERF_CNT_EN adds branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int PC_LSB      = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [2:0]      in_func3,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred_taken,
   input  logic [XLEN-1:0] in_pred_target,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_link,
   output logic            out_mispredict,
   output logic [XLEN-1:0] out_redirect_pc
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   kind_e           w_kind;
   logic            w_cond;
   logic            w_taken;
   logic            w_mispredict;
   logic            w_xfer;
   logic            w_train;
   logic [XLEN-1:0] w_br_target;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_link;
   logic [XLEN-1:0] w_redirect;
   logic            w_unused_ok;

   logic            out_valid_d;
   logic            out_valid_q;
   logic            taken_q;
   logic            mispredict_q;
   logic [XLEN-1:0] target_q;
   logic [XLEN-1:0] link_q;
   logic [XLEN-1:0] redirect_q;

   assign w_kind      = kind_e'(in_kind);
   assign w_br_target = in_pc + in_imm;
   assign w_jalr_sum  = in_rs1 + in_imm;
   assign w_link      = in_pc + XLEN'(4);

   always_comb begin
      w_cond = 1'b0;
      case (in_func3)
         BEQ:     w_cond = (in_rs1 == in_rs2);
         BNE:     w_cond = (in_rs1 != in_rs2);
         BLT:     w_cond = ($signed(in_rs1) <  $signed(in_rs2));
         BGE:     w_cond = ($signed(in_rs1) >= $signed(in_rs2));
         BLTU:    w_cond = (in_rs1 <  in_rs2);
         BGEU:    w_cond = (in_rs1 >= in_rs2);
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      w_taken  = 1'b0;
      w_target = w_br_target;
      case (w_kind)
         KIND_BRANCH: w_taken = w_cond;
         KIND_JAL:    w_taken = 1'b1;
         KIND_JALR: begin
            w_taken  = 1'b1;
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
         end
         default:     w_taken = 1'b0;
      endcase
   end

   // A not-taken result only mispredicts on direction; the target is ignored.
   assign w_mispredict = (w_taken != in_pred_taken) ||
                         (w_taken && (in_pred_target != w_target));
   assign w_redirect   = w_taken ? w_target : w_link;

   assign in_ready = !out_valid_q || out_ready;
   assign w_xfer   = in_valid && in_ready && !flush;
   assign w_train  = w_xfer && (w_kind == KIND_BRANCH);

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (w_xfer) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         taken_q      <= 1'b0;
         mispredict_q <= 1'b0;
         target_q     <= '0;
         link_q       <= '0;
         redirect_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (w_xfer) begin
            taken_q      <= w_taken;
            mispredict_q <= w_mispredict;
            target_q     <= w_target;
            link_q       <= w_link;
            redirect_q   <= w_redirect;
         end
      end
   end

   assign out_valid       = out_valid_q;
   assign out_taken       = taken_q;
   assign out_mispredict  = mispredict_q;
   assign out_target      = target_q;
   assign out_link        = link_q;
   assign out_redirect_pc = redirect_q;

   bht_2bit #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_i    (lookup_pc[PC_LSB +: IDX_W]),
      .rd_taken_o  (lookup_taken),
      .upd_en_i    (w_train),
      .upd_idx_i   (in_pc[PC_LSB +: IDX_W]),
      .upd_taken_i (w_taken)
   );

   assign w_unused_ok = ^lookup_pc;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q;
   logic [31:0] perf_mis_q;

   // A flushed cycle suppresses the output-side acceptance as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_br_q  <= 32'd0;
         perf_mis_q <= 32'd0;
      end else if (out_valid_q && out_ready && !flush) begin
         perf_br_q <= perf_br_q + 32'd1;
         if (mispredict_q) begin
            perf_mis_q <= perf_mis_q + 32'd1;
         end
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mis_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed and randomized checks of branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [2:0]  in_func3;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic        in_pred_taken;
   logic [31:0] in_pred_target;
   logic [31:0] lookup_pc;
   logic        lookup_taken;
   logic        out_valid;
   logic        out_ready;
   logic        out_taken;
   logic [31:0] out_target, out_link, out_redirect_pc;
   logic        out_mispredict;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic [31:0] redir;
      logic        mis;
   } res_t;

   // Reference state: one held result slot and an integer-valued counter table
   bit   mv;
   res_t held;
   int   bht [64];

   branch_resolve_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_kind         (in_kind),
      .in_func3        (in_func3),
      .in_pc           (in_pc),
      .in_rs1          (in_rs1),
      .in_rs2          (in_rs2),
      .in_imm          (in_imm),
      .in_pred_taken   (in_pred_taken),
      .in_pred_target  (in_pred_target),
      .lookup_pc       (lookup_pc),
      .lookup_taken    (lookup_taken),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_taken       (out_taken),
      .out_target      (out_target),
      .out_link        (out_link),
      .out_mispredict  (out_mispredict),
      .out_redirect_pc (out_redirect_pc)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   function automatic res_t ref_resolve(input logic [1:0] k, input logic [2:0] f3,
                                        input logic [31:0] pc, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] imm,
                                        input logic pt, input logic [31:0] ptg);
      res_t   r;
      longint s1, s2, u1, u2;
      logic [31:0] sum;
      s1 = longint'($signed(rs1));
      s2 = longint'($signed(rs2));
      u1 = longint'(rs1);
      u2 = longint'(rs2);
      r.taken = 1'b0;
      if (k == 2'd1 || k == 2'd2) r.taken = 1'b1;
      else if (k == 2'd0) begin
         case (f3)
            3'd0: r.taken = (u1 == u2);
            3'd1: r.taken = (u1 != u2);
            3'd4: r.taken = (s1 <  s2);
            3'd5: r.taken = (s1 >= s2);
            3'd6: r.taken = (u1 <  u2);
            3'd7: r.taken = (u1 >= u2);
            default: r.taken = 1'b0;
         endcase
      end
      r.link = pc + 32'd4;
      if (k == 2'd2) begin
         sum      = rs1 + imm;
         r.target = (sum / 2) * 2;
      end else begin
         r.target = pc + imm;
      end
      r.redir = r.taken ? r.target : r.link;
      if (!r.taken) r.mis = pt;
      else          r.mis = !pt || (ptg != r.target);
      return r;
   endfunction

   function automatic int bht_index(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   task automatic model_reset();
      mv = 1'b0;
      for (int i = 0; i < 64; i++) bht[i] = 1;
   endtask

   // Drives one cycle of inputs, checks combinational outputs before the edge
   // and registered outputs after it, advancing the reference model in between.
   task automatic cycle(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg, input logic iv,
                        input logic ordy, input logic fl, input logic [31:0] lpc);
      logic exp_rdy;
      int   li, pi;
      res_t r;
      in_kind = k; in_func3 = f3; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_pred_taken = pt; in_pred_target = ptg;
      in_valid = iv; out_ready = ordy; flush = fl; lookup_pc = lpc;
      #1;
      exp_rdy = !mv || ordy;
      li = bht_index(lpc);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("lookup_taken", {31'd0, lookup_taken}, (bht[li] >= 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      r = ref_resolve(k, f3, pc, rs1, rs2, imm, pt, ptg);
      if (fl) mv = 1'b0;
      else if (iv && exp_rdy) begin
         mv   = 1'b1;
         held = r;
         if (k == 2'd0) begin
            pi = bht_index(pc);
            if (r.taken) bht[pi] = (bht[pi] == 3) ? 3 : bht[pi] + 1;
            else         bht[pi] = (bht[pi] == 0) ? 0 : bht[pi] - 1;
         end
      end else if (ordy) mv = 1'b0;
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
      if (mv) begin
         chk("out_taken", {31'd0, out_taken}, {31'd0, held.taken});
         chk("out_target", out_target, held.target);
         chk("out_link", out_link, held.link);
         chk("out_mispredict", {31'd0, out_mispredict}, {31'd0, held.mis});
         chk("out_redirect_pc", out_redirect_pc, held.redir);
      end
   endtask

   task automatic idle(input logic ordy, input logic [31:0] lpc);
      cycle(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, ordy, 1'b0, lpc);
   endtask

   initial begin
      logic [1:0]  k;
      logic [2:0]  f3;
      logic [31:0] pc, rs1, rs2, imm, ptg, lpc;
      logic        pt;
      res_t        rr;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_kind = '0; in_func3 = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
      in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0; lookup_pc = 32'h40;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
      chk("rst_out_target", out_target, 32'd0);
      chk("rst_out_link", out_link, 32'd0);
      chk("rst_out_mispredict", {31'd0, out_mispredict}, 32'd0);
      chk("rst_out_redirect", out_redirect_pc, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_lookup", {31'd0, lookup_taken}, 32'd0);
      rst_n = 1'b1;

      // BLT signed: -1 < 1 taken, mispredicted
      cycle(2'd0, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("blt_taken", {31'd0, out_taken}, 32'd1);
      chk("blt_target", out_target, 32'h120);
      chk("blt_mispredict", {31'd0, out_mispredict}, 32'd1);
      chk("blt_redirect", out_redirect_pc, 32'h120);

      // BLTU same operands: not taken, correctly predicted
      cycle(2'd0, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h5555, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("bltu_taken", {31'd0, out_taken}, 32'd0);
      chk("bltu_mispredict", {31'd0, out_mispredict}, 32'd0);
      chk("bltu_redirect", out_redirect_pc, 32'h104);

      // JALR with odd sum clears bit 0
      cycle(2'd2, 3'b000, 32'h300, 32'h203, 32'd0, 32'd0, 1'b1, 32'h202, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("jalr_target", out_target, 32'h202);
      chk("jalr_link", out_link, 32'h304);
      chk("jalr_mispredict", {31'd0, out_mispredict}, 32'd0);

      // Four taken BEQs at 0x40 with lookup on the same PC
      cycle(2'd0, 3'b000, 32'h40, 32'd7, 32'd7, 32'h10, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h40);
      chk("bht_after1", {31'd0, lookup_taken}, 32'd1);
      repeat (3)
         cycle(2'd0, 3'b000, 32'h40, 32'd7, 32'd7, 32'h10, 1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 32'h40);
      chk("bht_sat_taken", {31'd0, lookup_taken}, 32'd1);
      repeat (3)
         cycle(2'd0, 3'b001, 32'h40, 32'd7, 32'd7, 32'h10, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h40);
      chk("bht_nt_low", {31'd0, lookup_taken}, 32'd0);
      idle(1'b1, 32'h40);

      // Backpressure: A held while B waits, then both drain in order
      cycle(2'd1, 3'b000, 32'h500, 32'd0, 32'd0, 32'h40, 1'b1, 32'h540, 1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) begin
         cycle(2'd0, 3'b000, 32'h600, 32'd1, 32'd2, 32'h8, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0);
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_target", out_target, 32'h540);
      end
      cycle(2'd0, 3'b000, 32'h600, 32'd1, 32'd2, 32'h8, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("bp_second_redirect", out_redirect_pc, 32'h604);
      idle(1'b1, 32'h0);

      // Flush with a held result and a transfer attempt on an untouched index
      cycle(2'd1, 3'b000, 32'h700, 32'd0, 32'd0, 32'h4, 1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 32'h80);
      cycle(2'd0, 3'b000, 32'h80, 32'd3, 32'd3, 32'h4, 1'b1, 32'h84, 1'b1, 1'b1, 1'b1, 32'h80);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      idle(1'b1, 32'h80);
      chk("flush_bht_unchanged", {31'd0, lookup_taken}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         k   = 2'($urandom_range(0, 3));
         f3  = 3'($urandom_range(0, 7));
         pc  = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 8'($urandom), 2'b00};
         rs1 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
         rs2 = ($urandom_range(0, 3) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? $urandom
                                                    : 32'($urandom_range(0, 4)) - 32'd2);
         imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
         pt  = 1'($urandom);
         rr  = ref_resolve(k, f3, pc, rs1, rs2, imm, 1'b0, 32'd0);
         ptg = ($urandom_range(0, 1) == 0) ? rr.target : $urandom;
         lpc = ($urandom_range(0, 1) == 0) ? pc : {22'd0, 8'($urandom), 2'b00};
         cycle(k, f3, pc, rs1, rs2, imm, pt, ptg,
               1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 99) < 8), lpc);
      end
      idle(1'b1, 32'h0);

      // Asynchronous reset mid-operation drops the held result and the BHT state
      cycle(2'd0, 3'b000, 32'hC0, 32'd1, 32'd1, 32'h8, 1'b1, 32'hC8, 1'b1, 1'b1, 1'b0, 32'hC0);
      cycle(2'd0, 3'b000, 32'hC0, 32'd1, 32'd1, 32'h8, 1'b1, 32'hC8, 1'b1, 1'b1, 1'b0, 32'hC0);
      cycle(2'd0, 3'b000, 32'hC0, 32'd1, 32'd1, 32'h8, 1'b1, 32'hC8, 1'b1, 1'b0, 1'b0, 32'hC0);
      chk("pre_reset_lookup", {31'd0, lookup_taken}, 32'd1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_out_target", out_target, 32'd0);
      chk("async_rst_out_redirect", out_redirect_pc, 32'd0);
      chk("async_rst_lookup", {31'd0, lookup_taken}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(2'd1, 3'b000, 32'h1000, 32'd0, 32'd0, 32'h100, 1'b1, 32'h1100, 1'b1, 1'b1, 1'b0, 32'hC0);
      idle(1'b1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined, parametrised branch resolution stage for the RISC-V core.
- Evaluates conditional branches (all six func3 compares), JAL and JALR, computes target and link, and compares the result against the fetch-stage prediction to flag mispredicts.
- Owns a 2-bit saturating branch history table (BHT) that fetch reads combinationally and that this unit trains on resolution.
- Sits between decode/execute and the fetch redirect logic, with one registered output stage and a valid/ready handshake.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of BHT counters; power of two, at least 2.
- PC_LSB, 2, lowest PC bit used for BHT indexing; index = pc[PC_LSB +: log2(BHT_ENTRIES)].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill the in-flight result and suppress any transfer this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept.
- in_kind  in  2  0=branch, 1=JAL, 2=JALR, 3=reserved (treated as branch not taken).
- in_func3  in  3  branch condition.
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  XLEN  operands.
- in_imm  in  XLEN  sign-extended immediate.
- in_pred_taken  in  1  fetch prediction.
- in_pred_target  in  XLEN  fetch predicted target.
- lookup_pc  in  XLEN  fetch-side BHT read address.
- lookup_taken  out  1  MSB of the indexed counter (combinational).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  resolved target.
- out_link  out  XLEN  in_pc+4.
- out_mispredict  out  1  redirect required.
- out_redirect_pc  out  XLEN  correct next PC.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; all other outputs 0; every BHT counter=2'b01 (weakly not taken). A reset asserted mid-operation drops any held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready.
  - Results appear on the output register exactly 1 cycle after the transfer and are held stable while out_valid && !out_ready.
  - Back-to-back transfers sustain 1 per cycle.
- Condition (kind=0):
  - BEQ/BNE compare for equality; BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - func3 010 and 011 resolve not taken.
- Targets:
  - Branch and JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - All adds wrap modulo 2^XLEN.
  - JAL and JALR are always taken.
- out_redirect_pc = taken ? target : pc+4.
- out_mispredict = (taken != pred_taken) || (taken && pred_target != target). A not-taken result with a not-taken prediction never mispredicts, regardless of pred_target.
- BHT training:
  - On a transfer with kind=0 and no flush, the counter at in_pc's index saturating-increments if taken and saturating-decrements if not.
  - 2'b11 stays at 11 on taken; 2'b00 stays at 00 on not taken.
  - JAL/JALR/reserved do not train.
- Read-during-write: lookup_taken returns the pre-update value; the new value is visible the next cycle.
- Flush:
  - flush=1 clears out_valid at the next edge.
  - A transfer in the same cycle is discarded and causes no BHT update.
  - in_ready is unaffected by flush.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_branches[31:0] and perf_mispredicts[31:0], both reset to 0.
  - Each counts results accepted on the output (out_valid && out_ready), with perf_mispredicts counting only those with out_mispredict=1.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package branch_pkg:
  - func3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - in_kind encodings.
  - 2-bit counter type and init value 2'b01.
- Sub-module bht_2bit: parametrised counter array with one async read port and one update port (index, taken, enable).

Test Plan:
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=0 -> 1 cycle later out_taken=1, out_target=0x120, out_mispredict=1, out_redirect_pc=0x120.
- BLTU with the same operands, pred_taken=0 -> out_taken=0, out_mispredict=0, out_redirect_pc=0x104.
- JALR, rs1=0x203, imm=0, pred_taken=1, pred_target=0x202 -> out_target=0x202, out_link=pc+4, out_mispredict=0.
- BHT training:
  - Four taken branches at pc=0x40: lookup_taken at 0x40 goes 0 then 1 (after the 1st update) and saturates at 11.
  - Three not-taken branches at 0x40: counter reaches 00; lookup_taken=0.
- Backpressure: hold out_ready=0 for 3 cycles with a second request pending -> in_ready=0, outputs stable. Raise out_ready -> both results delivered in order on consecutive cycles.
- Flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, BHT unchanged. With BRU_PERF_CNT_EN defined, counters are unchanged.
